// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port among NREQ requesters.
// Port 0 (pipeline writeback) has fixed top priority; side ports 1..NREQ-1
// are served round-robin, and a per-port starvation counter forces a grant
// to a side writer that has waited MAX_WAIT cycles. The outputs are registered
// and drive RegFile directly.

module rf_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(MAX_WAIT + 1)
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_wr,
    output logic [AW-1:0]        rf_addr,
    output logic [DW-1:0]        rf_data,
    output logic                 grant_vld,
    output logic [IDW-1:0]       grant_id
);

    // Side-port index reached by stepping 'off' places from 'base',
    // wrapping from NREQ-1 back to 1 (port 0 is never part of the ring).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int off);
        int s;
        s = int'(base) + off;
        if (s > NREQ - 1)
            s = s - (NREQ - 1);
        return IDW'(s);
    endfunction

    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   wait_cnt [1:NREQ-1];
    logic [NREQ-1:0] saturated;
    logic            override;
    logic [NREQ-1:0] side_cand;
    logic            side_found;
    logic [IDW-1:0]  side_idx;
    logic            xfer;
    logic [IDW-1:0]  sel_id;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // A side port is saturated once its wait counter hits MAX_WAIT; any
    // saturated port switches the arbiter into override mode.
    always_comb begin
        saturated = '0;
        for (int i = 1; i < NREQ; i++)
            saturated[i] = (wait_cnt[i] == CW'(MAX_WAIT));
        override = |saturated;
    end

    // Side ports eligible this cycle: all valid ones normally, only the
    // saturated valid ones while in override.
    always_comb begin
        side_cand = '0;
        for (int i = 1; i < NREQ; i++)
            side_cand[i] = req_valid[i] & (~override | saturated[i]);
    end

    // First eligible side port at or after rr_ptr, in ring order.
    always_comb begin
        side_found = 1'b0;
        side_idx   = '0;
        for (int j = 0; j < NREQ - 1; j++) begin
            if (!side_found && side_cand[wrap_idx(rr_ptr, j)]) begin
                side_found = 1'b1;
                side_idx   = wrap_idx(rr_ptr, j);
            end
        end
    end

    // One-hot accept: port 0 first unless in override, then the side winner.
    always_comb begin
        req_ready = '0;
        sel_id    = '0;
        if (!override && req_valid[0]) begin
            req_ready[0] = 1'b1;
            sel_id       = '0;
        end else if (side_found) begin
            req_ready[side_idx] = 1'b1;
            sel_id              = side_idx;
        end
        xfer = |req_ready;
    end

    // Mux the winning port's address and data toward the output register.
    always_comb begin
        sel_addr = req_addr[int'(sel_id)*AW +: AW];
        sel_data = req_data[int'(sel_id)*DW +: DW];
    end

    // Output register: a transfer shows up for one cycle; idle cycles clear
    // the strobes and leave address, data and id holding their last value.
    // Writes to register 0 are reported but not issued to the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_wr     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
        end else begin
            grant_vld <= xfer;
            rf_wr     <= xfer && (sel_addr != '0);
            if (xfer) begin
                rf_addr  <= sel_addr;
                rf_data  <= sel_data;
                grant_id <= sel_id;
            end
        end
    end

    // Round-robin pointer moves past a granted side port; port 0 grants
    // leave it where it is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= IDW'(1);
        end else if (xfer && sel_id != '0) begin
            if (sel_id == IDW'(NREQ - 1))
                rr_ptr <= IDW'(1);
            else
                rr_ptr <= sel_id + IDW'(1);
        end
    end

    // Starvation counters: count stalled cycles, saturate at MAX_WAIT,
    // restart whenever the port is served or drops its request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREQ; i++)
                wait_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREQ; i++) begin
                if (!req_valid[i] || req_ready[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != CW'(MAX_WAIT))
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Scenario bench for the register-file write arbiter. Each scenario drives
// requests on the falling edge, checks the combinational accept vector, and
// pushes the expected registered result onto a queue that is popped and
// compared one clock later.

module tb_rf_write_arbiter;

    localparam int NREQ     = 4;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_wr;
    logic [AW-1:0]        rf_addr;
    logic [DW-1:0]        rf_data;
    logic                 grant_vld;
    logic [1:0]           grant_id;

    typedef struct {
        logic        vld;
        logic [1:0]  id;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rf_write_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .reset(reset), .clk(clk),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
        .grant_vld(grant_vld), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Fixed per-port address and data used by the multi-port scenarios.
    function automatic logic [AW-1:0] port_addr(input int i);
        return AW'(8 + i * 3);
    endfunction

    function automatic logic [DW-1:0] port_data(input int i);
        return 32'hC0DE_0000 + 32'(i * 17 + 1);
    endfunction

    function automatic exp_t grant_of(input int g);
        exp_t e;
        e.vld  = 1'b1;
        e.id   = 2'(g);
        e.addr = port_addr(g);
        e.data = port_data(g);
        e.wr   = (e.addr != '0);
        return e;
    endfunction

    task automatic set_std(input logic [NREQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = port_addr(i);
            req_data[i*DW +: DW] = port_data(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Reset mid-traffic clears outputs at once and restarts rr_ptr at 1.
    task automatic test_reset();
        exp_t e;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rf_wr, rf_addr, rf_data, grant_vld, grant_id} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_init got wr=%b addr=%0d data=%h vld=%b id=%0d want all 0",
                     rf_wr, rf_addr, rf_data, grant_vld, grant_id);
        end
        reset = 1'b1;
        set_std(4'b0010);
        @(posedge clk); #1;
        @(negedge clk);
        set_std(4'b1110);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rf_wr, rf_addr, rf_data, grant_vld, grant_id} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_mid got wr=%b addr=%0d data=%h vld=%b id=%0d want all 0",
                     rf_wr, rf_addr, rf_data, grant_vld, grant_id);
        end
        @(negedge clk);
        reset = 1'b1;
        set_std(4'b1110);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("[TB] FAIL reset_rr_ready got=%b want=%b", req_ready, 4'b0010);
        end
        exp_q.push_back(grant_of(1));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
            n_err++;
            $display("[TB] FAIL reset_first_grant got vld=%b id=%0d wr=%b addr=%0d data=%h want vld=%b id=%0d wr=%b addr=%0d data=%h",
                     grant_vld, grant_id, rf_wr, rf_addr, rf_data, e.vld, e.id, e.wr, e.addr, e.data);
        end
    endtask

    // Single side-port write, then an idle cycle that must hold the bus.
    task automatic test_single();
        exp_t e;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_addr  = '0;
        req_data  = '0;
        req_addr[2*AW +: AW] = 5'd5;
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("[TB] FAIL single_ready got=%b want=%b", req_ready, 4'b0100);
        end
        exp_q.push_back('{1'b1, 2'd2, 1'b1, 5'd5, 32'hDEADBEEF});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
            n_err++;
            $display("[TB] FAIL single_out got vld=%b id=%0d wr=%b addr=%0d data=%h want vld=%b id=%0d wr=%b addr=%0d data=%h",
                     grant_vld, grant_id, rf_wr, rf_addr, rf_data, e.vld, e.id, e.wr, e.addr, e.data);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL idle_ready got=%b want=%b", req_ready, 4'b0000);
        end
        exp_q.push_back('{1'b0, 2'd2, 1'b0, 5'd5, 32'hDEADBEEF});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
            n_err++;
            $display("[TB] FAIL idle_hold got vld=%b id=%0d wr=%b addr=%0d data=%h want vld=%b id=%0d wr=%b addr=%0d data=%h",
                     grant_vld, grant_id, rf_wr, rf_addr, rf_data, e.vld, e.id, e.wr, e.addr, e.data);
        end
    endtask

    // Three side ports held valid rotate 1,2,3,1,2 with no gaps.
    task automatic test_round_robin();
        exp_t e;
        int   ids[5];
        ids = '{1, 2, 3, 1, 2};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_std(4'b1110);
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << ids[c])) begin
                n_err++;
                $display("[TB] FAIL rr_ready c=%0d got=%b want=%b", c, req_ready, 4'b0001 << ids[c]);
            end
            exp_q.push_back(grant_of(ids[c]));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
                n_err++;
                $display("[TB] FAIL rr_out c=%0d got vld=%b id=%0d wr=%b addr=%0d want vld=%b id=%0d wr=%b addr=%0d",
                         c, grant_vld, grant_id, rf_wr, rf_addr, e.vld, e.id, e.wr, e.addr);
            end
        end
    endtask

    // Port 0 hogs the bus; port 1 is forced through on its ninth stalled cycle.
    task automatic test_starvation();
        exp_t e;
        int   g;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            g = (c == 8) ? 1 : 0;
            @(negedge clk);
            set_std(4'b0011);
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << g)) begin
                n_err++;
                $display("[TB] FAIL starve_ready c=%0d got=%b want=%b", c, req_ready, 4'b0001 << g);
            end
            exp_q.push_back(grant_of(g));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
                n_err++;
                $display("[TB] FAIL starve_out c=%0d got vld=%b id=%0d wr=%b addr=%0d want vld=%b id=%0d wr=%b addr=%0d",
                         c, grant_vld, grant_id, rf_wr, rf_addr, e.vld, e.id, e.wr, e.addr);
            end
        end
    endtask

    // A write to register 0 is accepted and reported but not issued.
    task automatic test_zero_addr();
        exp_t e;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_addr  = '0;
        req_data  = '0;
        req_data[0 +: DW] = 32'h1234;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("[TB] FAIL zero_ready got=%b want=%b", req_ready, 4'b0001);
        end
        exp_q.push_back('{1'b1, 2'd0, 1'b0, 5'd0, 32'h1234});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
            n_err++;
            $display("[TB] FAIL zero_out got vld=%b id=%0d wr=%b addr=%0d data=%h want vld=%b id=%0d wr=%b addr=%0d data=%h",
                     grant_vld, grant_id, rf_wr, rf_addr, rf_data, e.vld, e.id, e.wr, e.addr, e.data);
        end
    endtask

    // Port 3 stalls 5, withdraws once, then needs 8 fresh stalls to force.
    task automatic test_restart();
        exp_t e;
        int   g;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            g = (c == 14) ? 3 : 0;
            @(negedge clk);
            set_std((c == 5) ? 4'b0001 : 4'b1001);
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << g)) begin
                n_err++;
                $display("[TB] FAIL restart_ready c=%0d got=%b want=%b", c, req_ready, 4'b0001 << g);
            end
            exp_q.push_back(grant_of(g));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
                n_err++;
                $display("[TB] FAIL restart_out c=%0d got vld=%b id=%0d wr=%b addr=%0d want vld=%b id=%0d wr=%b addr=%0d",
                         c, grant_vld, grant_id, rf_wr, rf_addr, e.vld, e.id, e.wr, e.addr);
            end
        end
    endtask

    // A saturated port withdrawing leaves one empty override cycle, then
    // port 0 resumes.
    task automatic test_withdraw();
        exp_t e;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            set_std((c == 8) ? 4'b0001 : 4'b0011);
            #1;
            n_cmp++;
            if (req_ready !== ((c == 8) ? 4'b0000 : 4'b0001)) begin
                n_err++;
                $display("[TB] FAIL withdraw_ready c=%0d got=%b want=%b", c, req_ready,
                         (c == 8) ? 4'b0000 : 4'b0001);
            end
            if (c == 8) begin
                e = grant_of(0);
                e.vld = 1'b0;
                e.wr  = 1'b0;
                exp_q.push_back(e);
            end else begin
                exp_q.push_back(grant_of(0));
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({grant_vld, grant_id, rf_wr, rf_addr, rf_data} !== {e.vld, e.id, e.wr, e.addr, e.data}) begin
                n_err++;
                $display("[TB] FAIL withdraw_out c=%0d got vld=%b id=%0d wr=%b addr=%0d want vld=%b id=%0d wr=%b addr=%0d",
                         c, grant_vld, grant_id, rf_wr, rf_addr, e.vld, e.id, e.wr, e.addr);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_zero_addr();
        test_restart();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
